// File: rtl/exe_stage_multicycle_if.sv
// Execute-stage bus: operands, forwarding selects and controls in,
// result, forwarded store data and handshake out.
interface exe_stage_multicycle_if #(
  parameter int WORD_LEN     = 32,
  parameter int CMD_LEN      = 4,
  parameter int FORW_SEL_LEN = 2
);
  logic                    valid_in;
  logic                    freeze;
  logic [CMD_LEN-1:0]      EXE_CMD;
  logic [FORW_SEL_LEN-1:0] val1_sel;
  logic [FORW_SEL_LEN-1:0] val2_sel;
  logic [FORW_SEL_LEN-1:0] ST_val_sel;
  logic [WORD_LEN-1:0]     val1;
  logic [WORD_LEN-1:0]     val2;
  logic [WORD_LEN-1:0]     ALU_res_MEM;
  logic [WORD_LEN-1:0]     result_WB;
  logic [WORD_LEN-1:0]     ST_value_in;
  logic [WORD_LEN-1:0]     ALUResult;
  logic [WORD_LEN-1:0]     ST_value_out;
  logic                    valid_out;
  logic                    stall_out;

  modport master (
    output valid_in, freeze, EXE_CMD, val1_sel, val2_sel, ST_val_sel,
           val1, val2, ALU_res_MEM, result_WB, ST_value_in,
    input  ALUResult, ST_value_out, valid_out, stall_out
  );

  modport slave (
    input  valid_in, freeze, EXE_CMD, val1_sel, val2_sel, ST_val_sel,
           val1, val2, ALU_res_MEM, result_WB, ST_value_in,
    output ALUResult, ST_value_out, valid_out, stall_out
  );
endinterface

// File: rtl/exe_stage_multicycle.sv
// Execute stage with operand forwarding, a single-cycle ALU and an
// iterative shift-add multiplier / restoring divider that stalls upstream.
module exe_stage_multicycle #(
  parameter int WORD_LEN     = 32,
  parameter int CMD_LEN      = 4,
  parameter int FORW_SEL_LEN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  exe_stage_multicycle_if.slave bus
);
  localparam int SHW = $clog2(WORD_LEN);
  localparam int CW  = $clog2(WORD_LEN);

  localparam logic [CMD_LEN-1:0] C_ADD   = CMD_LEN'(0);
  localparam logic [CMD_LEN-1:0] C_SUB   = CMD_LEN'(1);
  localparam logic [CMD_LEN-1:0] C_AND   = CMD_LEN'(2);
  localparam logic [CMD_LEN-1:0] C_OR    = CMD_LEN'(3);
  localparam logic [CMD_LEN-1:0] C_NOR   = CMD_LEN'(4);
  localparam logic [CMD_LEN-1:0] C_XOR   = CMD_LEN'(5);
  localparam logic [CMD_LEN-1:0] C_SLL   = CMD_LEN'(6);
  localparam logic [CMD_LEN-1:0] C_SRL   = CMD_LEN'(7);
  localparam logic [CMD_LEN-1:0] C_SRA   = CMD_LEN'(8);
  localparam logic [CMD_LEN-1:0] C_SLT   = CMD_LEN'(9);
  localparam logic [CMD_LEN-1:0] C_MUL   = CMD_LEN'(10);
  localparam logic [CMD_LEN-1:0] C_MULHU = CMD_LEN'(11);
  localparam logic [CMD_LEN-1:0] C_DIVU  = CMD_LEN'(12);
  localparam logic [CMD_LEN-1:0] C_REMU  = CMD_LEN'(13);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state;
  logic [WORD_LEN-1:0] r_a;
  logic [WORD_LEN-1:0] r_b;
  logic [WORD_LEN-1:0] r_hi;       // product high word / remainder
  logic [WORD_LEN-1:0] r_lo;       // product low word / quotient
  logic [CW-1:0]       r_cnt;
  logic                r_is_div;
  logic                r_sel_hi;   // MULHU and REMU deliver the high half

  logic [WORD_LEN-1:0] w_a;
  logic [WORD_LEN-1:0] w_b;
  logic [WORD_LEN-1:0] w_alu;
  logic                w_is_multi;
  logic                w_is_div;
  logic                w_start;
  logic [WORD_LEN:0]   w_mul_sum;
  logic [WORD_LEN:0]   w_div_shift;
  logic [WORD_LEN:0]   w_div_diff;
  logic [WORD_LEN-1:0] w_next_hi;
  logic [WORD_LEN-1:0] w_next_lo;
  logic [WORD_LEN-1:0] w_final;

  // Selects 1 and 2 pick the MEM and WB results; 0 and 3 keep the own value.
  function automatic logic [WORD_LEN-1:0] fwd(
    input logic [FORW_SEL_LEN-1:0] sel,
    input logic [WORD_LEN-1:0]     own,
    input logic [WORD_LEN-1:0]     mem,
    input logic [WORD_LEN-1:0]     wb
  );
    logic [WORD_LEN-1:0] res;
    if (sel == FORW_SEL_LEN'(1)) begin
      res = mem;
    end else if (sel == FORW_SEL_LEN'(2)) begin
      res = wb;
    end else begin
      res = own;
    end
    return res;
  endfunction

  assign w_a              = fwd(bus.val1_sel, bus.val1, bus.ALU_res_MEM, bus.result_WB);
  assign w_b              = fwd(bus.val2_sel, bus.val2, bus.ALU_res_MEM, bus.result_WB);
  assign bus.ST_value_out = fwd(bus.ST_val_sel, bus.ST_value_in, bus.ALU_res_MEM, bus.result_WB);

  assign w_is_multi = (bus.EXE_CMD == C_MUL) || (bus.EXE_CMD == C_MULHU) ||
                      (bus.EXE_CMD == C_DIVU) || (bus.EXE_CMD == C_REMU);
  assign w_is_div   = (bus.EXE_CMD == C_DIVU) || (bus.EXE_CMD == C_REMU);
  assign w_start    = (r_state == S_IDLE) && bus.valid_in && w_is_multi;

  // Single-cycle ALU; multi-cycle opcodes, NOP and reserved give zero here.
  always_comb begin
    w_alu = '0;
    case (bus.EXE_CMD)
      C_ADD:   w_alu = w_a + w_b;
      C_SUB:   w_alu = w_a - w_b;
      C_AND:   w_alu = w_a & w_b;
      C_OR:    w_alu = w_a | w_b;
      C_NOR:   w_alu = ~(w_a | w_b);
      C_XOR:   w_alu = w_a ^ w_b;
      C_SLL:   w_alu = w_a << w_b[SHW-1:0];
      C_SRL:   w_alu = w_a >> w_b[SHW-1:0];
      C_SRA:   w_alu = $unsigned($signed(w_a) >>> w_b[SHW-1:0]);
      C_SLT:   w_alu = {{(WORD_LEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: w_alu = '0;
    endcase
  end

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WORD_LEN+1){1'b0}});
  assign w_div_shift = {r_hi, r_lo[WORD_LEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  // One iteration: multiply adds A on the low multiplier bit then shifts right;
  // divide shifts the next dividend bit in and subtracts B when it fits.
  always_comb begin
    w_next_hi = r_hi;
    w_next_lo = r_lo;
    if (r_is_div) begin
      if (!w_div_diff[WORD_LEN]) begin
        w_next_hi = w_div_diff[WORD_LEN-1:0];
        w_next_lo = {r_lo[WORD_LEN-2:0], 1'b1};
      end else begin
        w_next_hi = w_div_shift[WORD_LEN-1:0];
        w_next_lo = {r_lo[WORD_LEN-2:0], 1'b0};
      end
    end else begin
      w_next_hi = w_mul_sum[WORD_LEN:1];
      w_next_lo = {w_mul_sum[0], r_lo[WORD_LEN-1:1]};
    end
  end

  assign w_final = r_sel_hi ? r_hi : r_lo;

  // Control FSM and iterative datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sel_hi <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_cnt    <= CW'(WORD_LEN-1);
            r_is_div <= w_is_div;
            r_sel_hi <= (bus.EXE_CMD == C_MULHU) || (bus.EXE_CMD == C_REMU);
            if (w_is_div && (w_b == '0)) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              r_hi    <= w_a;
              r_lo    <= '1;
              r_state <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_a : w_b;
              r_state <= S_BUSY;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_DONE: begin
          if (!bus.freeze) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output mux: combinational ALU in IDLE, held result in DONE, quiet in reset.
  always_comb begin
    bus.ALUResult = w_alu;
    bus.valid_out = 1'b0;
    bus.stall_out = 1'b0;
    if (rst) begin
      bus.ALUResult = w_alu;
      bus.valid_out = 1'b0;
      bus.stall_out = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.valid_out = bus.valid_in && !w_is_multi;
          bus.stall_out = w_start;
        end
        S_BUSY: begin
          bus.valid_out = 1'b0;
          bus.stall_out = 1'b1;
        end
        S_DONE: begin
          bus.ALUResult = w_final;
          bus.valid_out = 1'b1;
          bus.stall_out = 1'b0;
        end
        default: begin
          bus.valid_out = 1'b0;
          bus.stall_out = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exe_stage_multicycle.sv
// Directed bench for exe_stage_multicycle with an expected-result queue.
module tb_exe_stage_multicycle;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [W-1:0] q[$];

  exe_stage_multicycle_if #(.WORD_LEN(W), .CMD_LEN(4), .FORW_SEL_LEN(2)) bus ();

  exe_stage_multicycle #(.WORD_LEN(W), .CMD_LEN(4), .FORW_SEL_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] fsel(input logic [1:0] sel, input logic [W-1:0] own,
                                        input logic [W-1:0] mem, input logic [W-1:0] wb);
    if (sel == 2'd1) return mem;
    else if (sel == 2'd2) return wb;
    else return own;
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] cmd, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int sh;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sh = int'(b % W);
    case (cmd)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ~(a | b);
      4'd5:  return a ^ b;
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return $unsigned($signed(a) >>> sh);
      4'd9:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (b == '0) ? {W{1'b1}} : a / b;
      4'd13: return (b == '0) ? a : a % b;
      default: return W'(0);
    endcase
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [W-1:0] v1, input logic [W-1:0] v2,
                       input logic [W-1:0] mem, input logic [W-1:0] wb);
    bus.valid_in    = 1'b1;
    bus.EXE_CMD     = cmd;
    bus.val1_sel    = s1;
    bus.val2_sel    = s2;
    bus.val1        = v1;
    bus.val2        = v2;
    bus.ALU_res_MEM = mem;
    bus.result_WB   = wb;
    q.push_back(model(cmd, fsel(s1, v1, mem, wb), fsel(s2, v2, mem, wb)));
  endtask

  task automatic run_single(input string tag, input logic [3:0] cmd,
                            input logic [1:0] s1, input logic [1:0] s2,
                            input logic [W-1:0] v1, input logic [W-1:0] v2,
                            input logic [W-1:0] mem, input logic [W-1:0] wb);
    @(posedge clk); #1;
    drive(cmd, s1, s2, v1, v2, mem, wb);
    #1;
    chk({tag, "_valid"}, W'(bus.valid_out), W'(1));
    chk({tag, "_stall"}, W'(bus.stall_out), W'(0));
    chk({tag, "_res"}, bus.ALUResult, q.pop_front());
  endtask

  task automatic run_multi(input string tag, input logic [3:0] cmd,
                           input logic [1:0] s1, input logic [1:0] s2,
                           input logic [W-1:0] v1, input logic [W-1:0] v2,
                           input logic [W-1:0] mem, input logic [W-1:0] wb,
                           input int exp_cycles, input bit scramble, input int n_freeze);
    int n;
    @(posedge clk); #1;
    drive(cmd, s1, s2, v1, v2, mem, wb);
    #1;
    chk({tag, "_t0_stall"}, W'(bus.stall_out), W'(1));
    chk({tag, "_t0_valid"}, W'(bus.valid_out), W'(0));
    n = 1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (scramble) begin
        bus.ALU_res_MEM = $urandom;
        bus.result_WB   = $urandom;
        bus.val1        = $urandom;
        bus.val2        = $urandom;
      end
      #1;
      if (!bus.stall_out) break;
      n++;
    end
    chk({tag, "_stall_cycles"}, W'(n), W'(exp_cycles));
    bus.valid_in = 1'b0;
    chk({tag, "_done_valid"}, W'(bus.valid_out), W'(1));
    chk({tag, "_res"}, bus.ALUResult, q[0]);
    for (int f = 0; f < n_freeze; f++) begin
      bus.freeze = 1'b1;
      @(posedge clk); #2;
      chk({tag, "_frz_valid"}, W'(bus.valid_out), W'(1));
      chk({tag, "_frz_res"}, bus.ALUResult, q[0]);
    end
    bus.freeze = 1'b0;
    void'(q.pop_front());
    @(posedge clk); #2;
    chk({tag, "_after_valid"}, W'(bus.valid_out), W'(0));
    chk({tag, "_after_stall"}, W'(bus.stall_out), W'(0));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    bus.freeze      = 1'b0;
    bus.ST_val_sel  = 2'd0;
    bus.ST_value_in = W'(32'h55);
    drive(4'd0, 2'd0, 2'd0, W'(3), W'(4), W'(0), W'(0));
    #2;
    chk("rst_stall", W'(bus.stall_out), W'(0));
    chk("rst_valid", W'(bus.valid_out), W'(0));
    chk("rst_comb_res", bus.ALUResult, q.pop_front());
    bus.valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_single("add_fwd", 4'd0, 2'd1, 2'd2, W'(100), W'(200), W'(5), W'(7));
    chk("add_fwd_const", bus.ALUResult, W'(12));
    bus.ST_val_sel = 2'd2;
    #1 chk("st_fwd_wb", bus.ST_value_out, W'(7));
    bus.ST_val_sel = 2'd3;
    #1 chk("st_own", bus.ST_value_out, W'(32'h55));
    run_single("sub", 4'd1, 2'd0, 2'd0, W'(3), W'(5), W'(0), W'(0));
    run_single("sra", 4'd8, 2'd0, 2'd3, W'(32'h8000_0010), W'(36), W'(0), W'(0));
    run_single("slt", 4'd9, 2'd0, 2'd0, W'(32'hFFFF_FFFF), W'(1), W'(0), W'(0));
    run_single("nor", 4'd4, 2'd0, 2'd1, W'(32'h0F0F_0000), W'(0), W'(32'h00F0), W'(0));
    run_single("nop", 4'd14, 2'd0, 2'd0, W'(9), W'(9), W'(0), W'(0));

    run_multi("mul", 4'd10, 2'd0, 2'd0, {W{1'b1}}, W'(2), W'(0), W'(0), W + 1, 1'b0, 0);
    run_multi("mulhu", 4'd11, 2'd0, 2'd0, {W{1'b1}}, W'(2), W'(0), W'(0), W + 1, 1'b0, 0);
    run_multi("divu", 4'd12, 2'd1, 2'd0, W'(0), W'(7), W'(100), W'(0), W + 1, 1'b1, 0);
    run_multi("remu", 4'd13, 2'd1, 2'd0, W'(0), W'(7), W'(100), W'(0), W + 1, 1'b1, 0);
    run_multi("divu0", 4'd12, 2'd0, 2'd2, W'(9), W'(5), W'(0), W'(0), 1, 1'b0, 0);
    run_multi("remu0", 4'd13, 2'd0, 2'd0, W'(9), W'(0), W'(0), W'(0), 1, 1'b0, 0);
    run_multi("mul_frz", 4'd10, 2'd0, 2'd0, W'(32'h1234), W'(32'h0101), W'(0), W'(0),
              W + 1, 1'b0, 3);

    @(posedge clk); #1;
    drive(4'd10, 2'd0, 2'd0, W'(77), W'(88), W'(0), W'(0));
    void'(q.pop_front());
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_stall", W'(bus.stall_out), W'(0));
    chk("rst_mid_valid", W'(bus.valid_out), W'(0));
    bus.valid_in = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    run_single("add_after_rst", 4'd0, 2'd0, 2'd0, W'(40), W'(2), W'(0), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
